subleq_uart_tx: RTL

- Output device that sits directly downstream of the SUBLEQ MMIO decoder's output port.
- Consumes each store to the output address through the out_req/out_ack handshake and buffers the word in a small FIFO.
- Serialises the low 8 bits of each word as 8N1 UART frames on tx.
- Provides backpressure: a full FIFO stalls the CPU store until a slot frees.

---
 rtl/subleq_uart_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/subleq_uart_tx.sv
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

// Generic FIFO: registered pointers and count, head word read combinationally.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: none internally; the owner must not push when full or pop when empty.
module sync_fifo #(
    parameter int W          = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_vld,
    input  logic [W-1:0]          push_dat,
    input  logic                  pop_vld,
    output logic [W-1:0]          head_dat,
    output logic [DEPTH_LOG2:0]   count
);
    logic [W-1:0]            mem [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            count <= count + (DEPTH_LOG2+1)'(push_vld) - (DEPTH_LOG2+1)'(pop_vld);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

// SUBLEQ output device: queues stored words and sends their low byte as 8N1 UART frames.
// Latency: out_ack one cycle after the accepting edge; tx start bit one cycle after that.
// Backpressure: a full FIFO withholds out_ack until a slot has been freed on an earlier edge.
module subleq_uart_tx #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       out_req,
    input  logic [`WORD_SIZE-1:0]      io_out,
    output logic                       out_ack,
    output logic                       tx,
    output logic                       busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH = (FIFO_DEPTH_LOG2+1)'(1 << FIFO_DEPTH_LOG2);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic                   armed;
    logic                   accept;
    logic                   pop_vld;
    logic [`WORD_SIZE-1:0]  head_dat;
    logic [1:0]             state;
    logic [CW-1:0]          clk_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   bit_end;
    logic                   unused_hi;

    // Full is judged on the pre-edge count, so a pop on the same edge does not admit a push.
    assign accept  = out_req & armed & (fifo_count != DEPTH);
    assign pop_vld = (state == IDLE) & (fifo_count != '0);
    assign bit_end = (clk_cnt == LAST_TICK);
    assign busy    = (state != IDLE) | (fifo_count != '0);
    assign unused_hi = ^head_dat[`WORD_SIZE-1:8];

    sync_fifo #(
        .W          (`WORD_SIZE),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (accept),
        .push_dat (io_out),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    // armed drops on accept and returns only once the request is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b1;
            out_ack <= 1'b0;
        end else begin
            out_ack <= accept;
            if (!out_req) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_vld) begin
                        shift   <= head_dat[7:0];
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
